// File: rtl/nes_controller_port_if.sv
// CPU-side bus of the NES controller port: one-cycle qualified bus cycle plus read data return.
interface nes_controller_port_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_rw_n;
  logic [7:0]  dout;
  logic        dout_oe;

  modport master (
    output cpu_ce,
    output cpu_addr,
    output cpu_din,
    output cpu_rw_n,
    input  dout,
    input  dout_oe
  );

  modport slave (
    input  cpu_ce,
    input  cpu_addr,
    input  cpu_din,
    input  cpu_rw_n,
    output dout,
    output dout_oe
  );
endinterface

// File: rtl/nes_controller_port.sv
// NES standard controller on $4016 (port 1) fed from a USB keycode; $4017 reads as an empty port 2.
// Strobe/latch/serial-shift protocol served to the CPU on cpu_ce-qualified bus cycles.
module nes_controller_port #(
  parameter logic [7:0] KC_A      = 8'h1D,
  parameter logic [7:0] KC_B      = 8'h1B,
  parameter logic [7:0] KC_SELECT = 8'h2C,
  parameter logic [7:0] KC_START  = 8'h28,
  parameter logic [7:0] KC_UP     = 8'h52,
  parameter logic [7:0] KC_DOWN   = 8'h51,
  parameter logic [7:0] KC_LEFT   = 8'h50,
  parameter logic [7:0] KC_RIGHT  = 8'h4F
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_keycode,
  output logic [7:0]           o_buttons_dbg,
  nes_controller_port_if.slave bus
);

  localparam logic [15:0] ADDR_P1 = 16'h4016;
  localparam logic [15:0] ADDR_P2 = 16'h4017;
  localparam logic [3:0]  CNT_END = 4'd8;

  logic [7:0] r_kc_q;
  logic       r_strobe;
  logic [7:0] r_shreg;
  logic [3:0] r_cnt;

  logic [7:0] w_buttons;
  logic       w_hit_p1;
  logic       w_hit_p2;
  logic       w_wr_p1;
  logic       w_rd_p1;
  logic       w_data_bit;

  always_comb begin
    w_buttons = 8'h00;
    case (r_kc_q)
      KC_A:      w_buttons = 8'b0000_0001;
      KC_B:      w_buttons = 8'b0000_0010;
      KC_SELECT: w_buttons = 8'b0000_0100;
      KC_START:  w_buttons = 8'b0000_1000;
      KC_UP:     w_buttons = 8'b0001_0000;
      KC_DOWN:   w_buttons = 8'b0010_0000;
      KC_LEFT:   w_buttons = 8'b0100_0000;
      KC_RIGHT:  w_buttons = 8'b1000_0000;
      default:   w_buttons = 8'h00;
    endcase
  end

  assign o_buttons_dbg = w_buttons;

  assign w_hit_p1 = (bus.cpu_addr == ADDR_P1);
  assign w_hit_p2 = (bus.cpu_addr == ADDR_P2);
  assign w_wr_p1  = bus.cpu_ce & ~bus.cpu_rw_n & w_hit_p1;
  assign w_rd_p1  = bus.cpu_ce &  bus.cpu_rw_n & w_hit_p1;

  // While strobe is high the register tracks the pad; this also latches on the 1->0 write edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_kc_q   <= 8'h00;
      r_strobe <= 1'b0;
      r_shreg  <= 8'hFF;
      r_cnt    <= CNT_END;
    end else begin
      r_kc_q <= i_keycode;
      if (w_wr_p1) begin
        r_strobe <= bus.cpu_din[0];
      end
      if (r_strobe) begin
        r_shreg <= w_buttons;
        r_cnt   <= 4'd0;
      end else if (w_rd_p1) begin
        r_shreg <= {1'b1, r_shreg[7:1]};
        if (r_cnt != CNT_END) begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    if (r_strobe) begin
      w_data_bit = w_buttons[0];
    end else if (r_cnt == CNT_END) begin
      w_data_bit = 1'b1;
    end else begin
      w_data_bit = r_shreg[0];
    end
  end

  // Upper bits mimic open bus ($40); port 2 has nothing attached.
  always_comb begin
    if (w_hit_p1) begin
      bus.dout = {7'b0100000, w_data_bit};
    end else begin
      bus.dout = 8'h40;
    end
    bus.dout_oe = bus.cpu_rw_n & (w_hit_p1 | w_hit_p2);
  end

endmodule
